// File: rtl/om_csr_bank_if.sv
// CSR request/response bundle between the SFU and the OM CSR bank.
// The master issues writes and reads; the slave returns registered read responses.
interface om_csr_bank_if #(
  parameter int NUM_LANES = 4,
  parameter int NUM_CTX   = 4,
  parameter int DATAW     = 32,
  parameter int ADDRW     = 12
);
  localparam int WIDW = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

  logic                       write_enable;
  logic [ADDRW-1:0]           write_addr;
  logic [WIDW-1:0]            write_wid;
  logic [NUM_LANES-1:0]       write_tmask;
  logic [NUM_LANES*DATAW-1:0] write_data;
  logic                       read_enable;
  logic [ADDRW-1:0]           read_addr;
  logic [WIDW-1:0]            read_wid;
  logic                       read_valid;
  logic [NUM_LANES*DATAW-1:0] read_data;

  modport master (
    output write_enable, write_addr, write_wid, write_tmask, write_data,
    output read_enable, read_addr, read_wid,
    input  read_valid, read_data
  );

  modport slave (
    input  write_enable, write_addr, write_wid, write_tmask, write_data,
    input  read_enable, read_addr, read_wid,
    output read_valid, read_data
  );
endinterface

// File: rtl/om_csr_bank.sv
// Output-merger CSR file: NUM_CTX double-buffered contexts of NUM_CSRS registers.
// Writes land in the staged copy; a COMMIT write publishes staged to active atomically.
module om_csr_bank #(
  parameter int              NUM_LANES = 4,
  parameter int              NUM_CTX   = 4,
  parameter int              NUM_CSRS  = 4,
  parameter int              DATAW     = 32,
  parameter int              ADDRW     = 12,
  parameter logic [ADDRW-1:0] BASE_ADDR = 12'h7C0,
  localparam int             WIDW      = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  om_csr_bank_if.slave              csr,
  input  logic [WIDW-1:0]           ctx_sel,
  output logic [NUM_CSRS*DATAW-1:0] ctx_csrs,
  output logic [NUM_CTX-1:0]        ctx_dirty,
  output logic                      bad_addr
);
  localparam int CSRW = (NUM_CSRS > 1) ? $clog2(NUM_CSRS) : 1;

  logic [DATAW-1:0] staged_r [NUM_CTX][NUM_CSRS];
  logic [DATAW-1:0] active_r [NUM_CTX][NUM_CSRS];
  logic [NUM_CTX-1:0] dirty_r;
  logic               bad_r;
  logic               read_valid_r;
  logic [NUM_LANES*DATAW-1:0] read_data_r;

  logic [ADDRW-1:0] wr_off_s;
  logic [ADDRW-1:0] rd_off_s;
  logic [CSRW-1:0]  wr_idx_s;
  logic [CSRW-1:0]  rd_idx_s;
  logic             wr_is_reg_s;
  logic             wr_is_commit_s;
  logic             wr_fire_s;
  logic             rd_is_reg_s;
  logic             rd_is_commit_s;
  logic [DATAW-1:0] wr_value_s;
  logic [DATAW-1:0] rd_word_s;

  // Source value of a write is the lane of the lowest active thread.
  function automatic logic [DATAW-1:0] first_lane(
    input logic [NUM_LANES-1:0]       tmask,
    input logic [NUM_LANES*DATAW-1:0] data
  );
    logic [DATAW-1:0] v;
    logic             found;
    v     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (tmask[i] && !found) begin
        v     = data[i*DATAW +: DATAW];
        found = 1'b1;
      end
    end
    return v;
  endfunction

  assign wr_off_s       = csr.write_addr - BASE_ADDR;
  assign rd_off_s       = csr.read_addr - BASE_ADDR;
  assign wr_idx_s       = wr_off_s[CSRW-1:0];
  assign rd_idx_s       = rd_off_s[CSRW-1:0];
  assign wr_is_reg_s    = (wr_off_s < ADDRW'(NUM_CSRS));
  assign wr_is_commit_s = (wr_off_s == ADDRW'(NUM_CSRS));
  assign rd_is_reg_s    = (rd_off_s < ADDRW'(NUM_CSRS));
  assign rd_is_commit_s = (rd_off_s == ADDRW'(NUM_CSRS));
  assign wr_fire_s      = csr.write_enable && (|csr.write_tmask);
  assign wr_value_s     = first_lane(csr.write_tmask, csr.write_data);

  // Read word selection from pre-edge state.
  always_comb begin
    rd_word_s = '0;
    if (rd_is_reg_s) begin
      rd_word_s = staged_r[csr.read_wid][rd_idx_s];
    end else if (rd_is_commit_s) begin
      rd_word_s = DATAW'(dirty_r);
    end else begin
      rd_word_s = '0;
    end
  end

  // Staged/active register storage and per-context dirty tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CTX; c++) begin
        for (int k = 0; k < NUM_CSRS; k++) begin
          staged_r[c][k] <= '0;
          active_r[c][k] <= '0;
        end
      end
      dirty_r <= '0;
    end else if (wr_fire_s) begin
      if (wr_is_reg_s) begin
        staged_r[csr.write_wid][wr_idx_s] <= wr_value_s;
        dirty_r[csr.write_wid]            <= 1'b1;
      end else if (wr_is_commit_s) begin
        for (int k = 0; k < NUM_CSRS; k++) begin
          active_r[csr.write_wid][k] <= staged_r[csr.write_wid][k];
        end
        dirty_r[csr.write_wid] <= 1'b0;
      end
    end
  end

  // Sticky out-of-range flag, set by either port.
  always_ff @(posedge clk) begin
    if (reset) begin
      bad_r <= 1'b0;
    end else if ((wr_fire_s && !wr_is_reg_s && !wr_is_commit_s) ||
                 (csr.read_enable && !rd_is_reg_s && !rd_is_commit_s)) begin
      bad_r <= 1'b1;
    end
  end

  // One-cycle registered read response; data holds when no read is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_valid_r <= 1'b0;
      read_data_r  <= '0;
    end else begin
      read_valid_r <= csr.read_enable;
      if (csr.read_enable) begin
        read_data_r <= {NUM_LANES{rd_word_s}};
      end
    end
  end

  // Active copy of the datapath's context.
  always_comb begin
    ctx_csrs = '0;
    for (int k = 0; k < NUM_CSRS; k++) begin
      ctx_csrs[k*DATAW +: DATAW] = active_r[ctx_sel][k];
    end
  end

  assign ctx_dirty      = dirty_r;
  assign bad_addr       = bad_r;
  assign csr.read_valid = read_valid_r;
  assign csr.read_data  = read_data_r;
endmodule

// File: tb/tb_om_csr_bank.sv
// Directed self-checking bench for om_csr_bank with hand-computed expectations.
module tb_om_csr_bank;
  localparam logic [11:0] BASE = 12'h7C0;

  logic         clk;
  logic         reset;
  logic [1:0]   ctx_sel;
  logic [127:0] ctx_csrs;
  logic [3:0]   ctx_dirty;
  logic         bad_addr;
  int           tests_run;
  int           tests_failed;

  om_csr_bank_if #(.NUM_LANES(4), .NUM_CTX(4), .DATAW(32), .ADDRW(12)) bus ();

  om_csr_bank dut (
    .clk       (clk),
    .reset     (reset),
    .csr       (bus),
    .ctx_sel   (ctx_sel),
    .ctx_csrs  (ctx_csrs),
    .ctx_dirty (ctx_dirty),
    .bad_addr  (bad_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [1:0] wid,
                    input logic [3:0] tmask, input logic [127:0] data);
    bus.write_enable = 1'b1;
    bus.write_addr   = addr;
    bus.write_wid    = wid;
    bus.write_tmask  = tmask;
    bus.write_data   = data;
    step();
    bus.write_enable = 1'b0;
  endtask

  task automatic rd(input logic [11:0] addr, input logic [1:0] wid);
    bus.read_enable = 1'b1;
    bus.read_addr   = addr;
    bus.read_wid    = wid;
    step();
    bus.read_enable = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b, c, d;
    a = 32'hAAAA0001; b = 32'hBBBB0002; c = 32'hCCCC0003; d = 32'hDDDD0004;
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    ctx_sel = 2'd0;
    bus.write_enable = 1'b0; bus.write_addr = 12'h000; bus.write_wid = 2'd0;
    bus.write_tmask = 4'b0000; bus.write_data = '0;
    bus.read_enable = 1'b0; bus.read_addr = 12'h000; bus.read_wid = 2'd0;
    step(); step();
    reset = 1'b0;

    check("rst_read_valid", 128'(bus.read_valid), 128'd0);
    check("rst_read_data",  bus.read_data, 128'd0);
    check("rst_dirty",      128'(ctx_dirty), 128'd0);
    check("rst_bad",        128'(bad_addr), 128'd0);
    check("rst_ctx_csrs",   ctx_csrs, 128'd0);

    // Every in-range address of ctx 0 reads zero, one cycle after the strobe.
    for (int i = 0; i <= 4; i++) begin
      rd(BASE + 12'(i), 2'd0);
      check($sformatf("rd0_valid_%0d", i), 128'(bus.read_valid), 128'd1);
      check($sformatf("rd0_data_%0d", i), bus.read_data, 128'd0);
    end
    step();
    check("rd_valid_drop", 128'(bus.read_valid), 128'd0);
    check("rd_bad_clear",  128'(bad_addr), 128'd0);

    // Lowest active lane of tmask 0110 is lane 1 (B).
    ctx_sel = 2'd2;
    wr(BASE + 12'd1, 2'd2, 4'b0110, {d, c, b, a});
    check("wr_dirty",          128'(ctx_dirty), 128'h4);
    check("wr_ctx_unpublished", ctx_csrs, 128'd0);
    rd(BASE + 12'd1, 2'd2);
    check("wr_staged_b", bus.read_data, {b, b, b, b});
    wr(BASE + 12'd4, 2'd2, 4'b0001, 128'hFFFF);
    check("commit_ctx_csrs", ctx_csrs, {32'd0, 32'd0, b, 32'd0});
    check("commit_dirty",    128'(ctx_dirty), 128'd0);

    // Same-cycle read and write returns the old staged value.
    bus.write_enable = 1'b1; bus.write_addr = BASE + 12'd1; bus.write_wid = 2'd2;
    bus.write_tmask = 4'b0001; bus.write_data = 128'h55;
    bus.read_enable = 1'b1; bus.read_addr = BASE + 12'd1; bus.read_wid = 2'd2;
    step();
    bus.write_enable = 1'b0; bus.read_enable = 1'b0;
    check("rw_old_value", bus.read_data, {b, b, b, b});
    rd(BASE + 12'd1, 2'd2);
    check("rw_new_value",   bus.read_data, {4{32'h00000055}});
    check("rw_active_kept", ctx_csrs, {32'd0, 32'd0, b, 32'd0});

    // tmask 0 is a full no-op.
    wr(BASE + 12'd0, 2'd0, 4'b0000, {4{32'h99}});
    check("tm0_dirty", 128'(ctx_dirty), 128'h4);
    rd(BASE + 12'd0, 2'd0);
    check("tm0_staged", bus.read_data, 128'd0);
    check("tm0_bad",    128'(bad_addr), 128'd0);

    // Out-of-range write sets a sticky flag; out-of-range read returns 0.
    wr(BASE + 12'd7, 2'd0, 4'b0001, 128'h1234);
    check("oor_wr_bad", 128'(bad_addr), 128'd1);
    step(); step();
    check("oor_sticky", 128'(bad_addr), 128'd1);
    check("oor_wr_dirty", 128'(ctx_dirty), 128'h4);
    rd(BASE + 12'd1, 2'd2);
    check("oor_pre_read", bus.read_data, {4{32'h00000055}});
    rd(BASE + 12'd7, 2'd0);
    check("oor_rd_zero", bus.read_data, 128'd0);
    check("oor_rd_bad",  128'(bad_addr), 128'd1);

    // Publish ctx 2, then dirty ctx 1 and ctx 3 only.
    wr(BASE + 12'd4, 2'd2, 4'b1111, 128'd0);
    check("commit2_csrs", ctx_csrs, {32'd0, 32'd0, 32'h55, 32'd0});
    wr(BASE + 12'd0, 2'd1, 4'b0001, {d, c, b, a});
    wr(BASE + 12'd2, 2'd3, 4'b1000, {d, c, b, a});
    check("dirty_1_3", 128'(ctx_dirty), 128'hA);
    rd(BASE + 12'd4, 2'd0);
    check("commit_rd_dirty", bus.read_data, {4{32'h0000000A}});
    rd(BASE + 12'd2, 2'd3);
    check("lane3_select", bus.read_data, {d, d, d, d});
    ctx_sel = 2'd1;
    #1;
    check("ctx1_unpublished", ctx_csrs, 128'd0);
    ctx_sel = 2'd2;
    #1;
    check("ctx2_isolated", ctx_csrs, {32'd0, 32'd0, 32'h55, 32'd0});

    // Reset with a read in flight clears everything on that edge.
    reset = 1'b1;
    bus.read_enable = 1'b1; bus.read_addr = BASE + 12'd1; bus.read_wid = 2'd2;
    step();
    reset = 1'b0; bus.read_enable = 1'b0;
    check("mid_rst_valid", 128'(bus.read_valid), 128'd0);
    check("mid_rst_data",  bus.read_data, 128'd0);
    check("mid_rst_dirty", 128'(ctx_dirty), 128'd0);
    check("mid_rst_bad",   128'(bad_addr), 128'd0);
    check("mid_rst_csrs",  ctx_csrs, 128'd0);

    // Commit on a clean context is a no-op; an out-of-range read alone sets the flag.
    wr(BASE + 12'd4, 2'd2, 4'b0001, 128'd0);
    check("clean_commit_csrs",  ctx_csrs, 128'd0);
    check("clean_commit_dirty", 128'(ctx_dirty), 128'd0);
    rd(BASE + 12'd5, 2'd0);
    check("oor_rd_only_bad",  128'(bad_addr), 128'd1);
    check("oor_rd_only_data", bus.read_data, 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
